fft_frame_packer: RTL and testbench

- Upstream neighbour of the variable-length streaming FFT core.
- Accepts a flat stream of complex samples over a valid/ready handshake.
- Groups the samples into FFT frames of programmable power-of-two length.
- Drives the FFT core's Avalon-ST sink interface: valid/ready, sop/eop, error, real/imag, fftpts_in.
- Absorbs sink_ready backpressure with a 2-entry skid buffer, so every output is registered.

---
 rtl/fft_frame_packer_if.sv | 33 +++
 rtl/fft_frame_packer.sv | 165 ++++++++++++++++
 tb/tb_fft_frame_packer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_frame_packer_if.sv
// Stream bundle between the upstream sample source, the frame packer and
// the FFT core's Avalon-ST sink.
//   slave  : the packer (consumes in_*, produces sink_*)
//   master : the environment (upstream source plus the FFT sink)
interface fft_frame_packer_if #(
  parameter int DATA_W = 32,
  parameter int PTS_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_real;
  logic [DATA_W-1:0] in_imag;
  logic              sink_valid;
  logic              sink_ready;
  logic [1:0]        sink_error;
  logic              sink_sop;
  logic              sink_eop;
  logic [DATA_W-1:0] sink_real;
  logic [DATA_W-1:0] sink_imag;
  logic [PTS_W-1:0]  fftpts_in;

  modport slave (
    input  in_valid, in_real, in_imag, sink_ready,
    output in_ready, sink_valid, sink_error, sink_sop, sink_eop,
           sink_real, sink_imag, fftpts_in
  );

  modport master (
    output in_valid, in_real, in_imag, sink_ready,
    input  in_ready, sink_valid, sink_error, sink_sop, sink_eop,
           sink_real, sink_imag, fftpts_in
  );
endinterface

// File: rtl/fft_frame_packer.sv
// fft_frame_packer: groups a flat complex sample stream into power-of-two
// frames for the streaming FFT sink. Frame tags (sop/eop/fftpts) are
// attached at acceptance and travel with the sample through a 2-entry skid
// buffer, so all sink outputs come straight from registers.
// Optional build macro FFT_PACK_STATS_EN adds frame_count / stall_count.
module fft_frame_packer #(
  parameter int DATA_W    = 32,
  parameter int MAX_LOG2N = 4,
  parameter int PTS_W     = MAX_LOG2N + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cfg_log2n,
  fft_frame_packer_if.slave bus,
  output logic       cfg_err,
  output logic       frame_done
`ifdef FFT_PACK_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [15:0] stall_count
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    logic              sop;
    logic              eop;
    logic [PTS_W-1:0]  pts;
  } entry_t;

  typedef enum logic {IDLE, FILL} state_t;

  localparam entry_t RST_ENTRY = '{re: '0, im: '0, sop: 1'b0, eop: 1'b0,
                                   pts: PTS_W'(1 << MAX_LOG2N)};

  state_t               state_q, state_d;
  logic [MAX_LOG2N-1:0] idx_q, idx_d;
  logic [2:0]           log2_q, log2_d;
  logic                 cfg_err_d;
  logic                 cfg_legal;
  logic [2:0]           cfg_eff;
  logic [PTS_W-1:0]     n_q;
  logic                 last;
  entry_t               new_e, e0, e1;
  logic                 e0_vld, e1_vld, e1_vld_nx;
  logic                 in_ready_q;
  logic                 push, pop;

  assign push      = bus.in_valid & in_ready_q;
  assign pop       = e0_vld & bus.sink_ready;
  assign cfg_legal = (cfg_log2n != 3'd0) && (cfg_log2n <= 3'(MAX_LOG2N));
  assign cfg_eff   = cfg_legal ? cfg_log2n : 3'(MAX_LOG2N);
  assign n_q       = PTS_W'(1) << log2_q;
  assign last      = (PTS_W'(idx_q) == n_q - PTS_W'(1));

  // framing state: frame length latch, sample index, sticky config error
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      log2_q  <= 3'(MAX_LOG2N);
      cfg_err <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      log2_q  <= log2_d;
      cfg_err <= cfg_err_d;
    end
  end

  // next framing state and the tags for the sample currently offered
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    log2_d    = log2_q;
    cfg_err_d = cfg_err;
    new_e     = '{re: bus.in_real, im: bus.in_imag, sop: 1'b0, eop: 1'b0, pts: n_q};
    case (state_q)
      IDLE: begin
        // length is taken from cfg only here, so mid-frame changes wait for sop
        new_e.sop = 1'b1;
        new_e.pts = PTS_W'(1) << cfg_eff;
        if (push) begin
          log2_d    = cfg_eff;
          cfg_err_d = cfg_err | ~cfg_legal;
          idx_d     = MAX_LOG2N'(1);
          state_d   = FILL;
        end
      end
      FILL: begin
        new_e.eop = last;
        if (push) begin
          if (last) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + MAX_LOG2N'(1);
          end
        end
      end
    endcase
  end

  // entry 1 is occupied after this cycle iff it stays full under a pop+push
  // or catches a push while entry 0 is stuck
  assign e1_vld_nx = pop ? (e1_vld & push) : (e1_vld | (push & e0_vld));

  // skid buffer: entry 0 feeds the sink, entry 1 absorbs one beat of backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      e0         <= RST_ENTRY;
      e1         <= RST_ENTRY;
      e0_vld     <= 1'b0;
      e1_vld     <= 1'b0;
      in_ready_q <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      in_ready_q <= ~e1_vld_nx;
      e1_vld     <= e1_vld_nx;
      frame_done <= pop & e0.eop;
      if (pop) begin
        if (e1_vld) begin
          e0 <= e1;
          if (push) e1 <= new_e;
        end else if (push) begin
          e0 <= new_e;
        end else begin
          e0_vld <= 1'b0;
        end
      end else if (push) begin
        if (e0_vld) begin
          e1 <= new_e;
        end else begin
          e0     <= new_e;
          e0_vld <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.sink_valid = e0_vld;
  assign bus.sink_error = 2'b00;
  assign bus.sink_sop   = e0.sop;
  assign bus.sink_eop   = e0.eop;
  assign bus.sink_real  = e0.re;
  assign bus.sink_imag  = e0.im;
  assign bus.fftpts_in  = e0.pts;

`ifdef FFT_PACK_STATS_EN
  // frame counter wraps, stall counter saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
      stall_count <= '0;
    end else begin
      if (frame_done) frame_count <= frame_count + 16'd1;
      if (e0_vld && !bus.sink_ready && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_frame_packer.sv
// Self-checking bench for fft_frame_packer. A negedge monitor records every
// accepted input sample and every delivered sink beat; each test rebuilds the
// expected beat list from the accepted samples using the framing rules.
module tb_fft_frame_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cfg_log2n = 3'd2;
  logic        cfg_err;
  logic        frame_done;
`ifdef FFT_PACK_STATS_EN
  logic [15:0] frame_count;
  logic [15:0] stall_count;
`endif

  fft_frame_packer_if #(.DATA_W(32), .PTS_W(5)) bus();

  fft_frame_packer #(.DATA_W(32), .MAX_LOG2N(4), .PTS_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_log2n  (cfg_log2n),
    .bus        (bus),
    .cfg_err    (cfg_err),
    .frame_done (frame_done)
`ifdef FFT_PACK_STATS_EN
    ,
    .frame_count(frame_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    logic [2:0]  cfg;
    int          cyc;
  } acc_t;

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    logic        sop;
    logic        eop;
    logic [4:0]  pts;
    int          cyc;
  } beat_t;

  acc_t  acc_q[$];
  beat_t obs_q[$];
  beat_t exp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int sr_mode = 0;     // 0: ready high, 1: random, 2: driven by the test
  int done_cnt = 0;
  int ir_evt = 0;
  int ir_viol = 0;
  bit pend = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (sr_mode == 0) bus.sink_ready = 1'b1;
    else if (sr_mode == 1) bus.sink_ready = 1'($urandom_range(0, 1));
  end

  // monitor: accepted samples, delivered beats, frame_done pulses, and
  // in_ready having to drop the cycle after the overflow entry fills
  initial forever begin
    @(negedge clk);
    if (pend && bus.in_ready) ir_viol++;
    pend = 1'b0;
    if (!rst) begin
      if (bus.in_valid && bus.in_ready) begin
        acc_q.push_back('{re: bus.in_real, im: bus.in_imag, cfg: cfg_log2n, cyc: cyc});
        if (bus.sink_valid && !bus.sink_ready) begin
          pend = 1'b1;
          ir_evt++;
        end
      end
      if (bus.sink_valid && bus.sink_ready)
        obs_q.push_back('{re: bus.sink_real, im: bus.sink_imag, sop: bus.sink_sop,
                          eop: bus.sink_eop, pts: bus.fftpts_in, cyc: cyc});
      if (frame_done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // reference framing: each frame starts at the cfg seen with its first
  // sample (illegal -> 16 points) and covers exactly that many samples
  task automatic build_exp();
    int rem = 0;
    int n = 16;
    beat_t b;
    exp_q.delete();
    foreach (acc_q[i]) begin
      b.sop = (rem == 0);
      if (rem == 0) begin
        n = (acc_q[i].cfg >= 1 && acc_q[i].cfg <= 4) ? (1 << acc_q[i].cfg) : 16;
        rem = n;
      end
      rem--;
      b.re  = acc_q[i].re;
      b.im  = acc_q[i].im;
      b.eop = (rem == 0);
      b.pts = 5'(n);
      b.cyc = 0;
      exp_q.push_back(b);
    end
  endtask

  task automatic clear_q();
    acc_q.delete();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic send(input int n, input int gap_pct);
    int tmo;
    for (int i = 0; i < n; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_real  = $urandom;
      bus.in_imag  = $urandom;
      tmo = 0;
      @(negedge clk);
      while (!bus.in_ready && tmo < 200) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo >= 200) begin
        total++; bad++;
        $display("FAIL send_timeout in_ready=0 for 200 cycles, required 1");
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (obs_q.size() < exp_q.size() && t < 400) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
    total++; if (bus.sink_valid !== 1'b0) begin bad++; $display("FAIL rst_sink_valid got %b want 0", bus.sink_valid); end
    total++; if ({bus.sink_sop, bus.sink_eop, bus.sink_error} !== 4'b0000) begin bad++; $display("FAIL rst_tags got %b want 0000", {bus.sink_sop, bus.sink_eop, bus.sink_error}); end
    total++; if ({bus.sink_real, bus.sink_imag} !== 64'd0) begin bad++; $display("FAIL rst_data got %h want 0", {bus.sink_real, bus.sink_imag}); end
    total++; if (bus.fftpts_in !== 5'd16) begin bad++; $display("FAIL rst_fftpts got %0d want 16", bus.fftpts_in); end
    total++; if ({cfg_err, frame_done} !== 2'b00) begin bad++; $display("FAIL rst_flags got %b want 00", {cfg_err, frame_done}); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    int d0;
    clear_q();
    d0 = done_cnt;
    cfg_log2n = 3'd2;
    sr_mode = 0;
    send(8, 0);
    build_exp();
    drain();
    total++; if (obs_q.size() != 8) begin bad++; $display("FAIL basic_count got %0d want 8", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if ({obs_q[i].re, obs_q[i].im, obs_q[i].sop, obs_q[i].eop, obs_q[i].pts} !==
          {exp_q[i].re, exp_q[i].im, exp_q[i].sop, exp_q[i].eop, exp_q[i].pts}) begin
        bad++;
        $display("FAIL basic_beat[%0d] got %h/%h sop=%b eop=%b pts=%0d want %h/%h sop=%b eop=%b pts=%0d", i,
                 obs_q[i].re, obs_q[i].im, obs_q[i].sop, obs_q[i].eop, obs_q[i].pts,
                 exp_q[i].re, exp_q[i].im, exp_q[i].sop, exp_q[i].eop, exp_q[i].pts);
      end
    end
    total++; if (done_cnt - d0 != 2) begin bad++; $display("FAIL basic_frame_done got %0d want 2", done_cnt - d0); end
    if (obs_q.size() == 8 && acc_q.size() == 8) begin
      total++; if (obs_q[0].cyc - acc_q[0].cyc != 1) begin bad++; $display("FAIL basic_latency got %0d want 1", obs_q[0].cyc - acc_q[0].cyc); end
      total++; if (obs_q[7].cyc - obs_q[0].cyc != 7) begin bad++; $display("FAIL basic_throughput got %0d want 7", obs_q[7].cyc - obs_q[0].cyc); end
    end
    total++; if (bus.sink_error !== 2'b00) begin bad++; $display("FAIL basic_error got %b want 00", bus.sink_error); end
  endtask

  task automatic test_backpressure();
    int d0, e0;
    clear_q();
    d0 = done_cnt;
    e0 = ir_evt;
    cfg_log2n = 3'd4;
    sr_mode = 2;
    bus.sink_ready = 1'b0;
    send(2, 0);
    @(negedge clk);
    total++; if ({bus.in_ready, bus.sink_valid} !== 2'b01) begin bad++; $display("FAIL bp_stall got in_ready/valid=%b want 01", {bus.in_ready, bus.sink_valid}); end
    sr_mode = 1;
    send(14, 20);
    sr_mode = 0;
    build_exp();
    drain();
    total++; if (obs_q.size() != 16) begin bad++; $display("FAIL bp_count got %0d want 16", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if ({obs_q[i].re, obs_q[i].im, obs_q[i].sop, obs_q[i].eop, obs_q[i].pts} !==
          {exp_q[i].re, exp_q[i].im, exp_q[i].sop, exp_q[i].eop, exp_q[i].pts}) begin
        bad++;
        $display("FAIL bp_beat[%0d] got %h/%h sop=%b eop=%b pts=%0d want %h/%h sop=%b eop=%b pts=%0d", i,
                 obs_q[i].re, obs_q[i].im, obs_q[i].sop, obs_q[i].eop, obs_q[i].pts,
                 exp_q[i].re, exp_q[i].im, exp_q[i].sop, exp_q[i].eop, exp_q[i].pts);
      end
    end
    if (obs_q.size() == 16) begin
      total++; if (obs_q[15].eop !== 1'b1) begin bad++; $display("FAIL bp_eop16 got %b want 1", obs_q[15].eop); end
    end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL bp_frame_done got %0d want 1", done_cnt - d0); end
    total++; if (ir_viol != 0 || ir_evt == e0) begin bad++; $display("FAIL bp_in_ready_drop late=%0d fills=%0d want late=0 fills>0", ir_viol, ir_evt - e0); end
  endtask

  task automatic test_cfg_change();
    int d0;
    clear_q();
    d0 = done_cnt;
    cfg_log2n = 3'd3;
    send(3, 0);
    cfg_log2n = 3'd1;
    send(7, 0);
    build_exp();
    drain();
    total++; if (obs_q.size() != 10) begin bad++; $display("FAIL cfgchg_count got %0d want 10", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if ({obs_q[i].re, obs_q[i].im, obs_q[i].sop, obs_q[i].eop, obs_q[i].pts} !==
          {exp_q[i].re, exp_q[i].im, exp_q[i].sop, exp_q[i].eop, exp_q[i].pts}) begin
        bad++;
        $display("FAIL cfgchg_beat[%0d] got %h/%h sop=%b eop=%b pts=%0d want %h/%h sop=%b eop=%b pts=%0d", i,
                 obs_q[i].re, obs_q[i].im, obs_q[i].sop, obs_q[i].eop, obs_q[i].pts,
                 exp_q[i].re, exp_q[i].im, exp_q[i].sop, exp_q[i].eop, exp_q[i].pts);
      end
    end
    if (obs_q.size() == 10) begin
      total++; if ({obs_q[7].eop, obs_q[7].pts} !== {1'b1, 5'd8}) begin bad++; $display("FAIL cfgchg_eop8 got eop=%b pts=%0d want 1/8", obs_q[7].eop, obs_q[7].pts); end
      total++; if ({obs_q[8].sop, obs_q[9].eop, obs_q[9].pts} !== {2'b11, 5'd2}) begin bad++; $display("FAIL cfgchg_frame2 got sop=%b eop=%b pts=%0d want 1/1/2", obs_q[8].sop, obs_q[9].eop, obs_q[9].pts); end
    end
    total++; if (done_cnt - d0 != 2) begin bad++; $display("FAIL cfgchg_frame_done got %0d want 2", done_cnt - d0); end
  endtask

  task automatic test_cfg_illegal();
    int d0;
    clear_q();
    d0 = done_cnt;
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL ill_cfg_err_before got %b want 0", cfg_err); end
    cfg_log2n = 3'd0;
    send(1, 0);
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL ill_cfg_err_rise got %b want 1", cfg_err); end
    send(15, 10);
    cfg_log2n = 3'd5;
    send(16, 10);
    build_exp();
    drain();
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL ill_cfg_err_sticky got %b want 1", cfg_err); end
    total++; if (obs_q.size() != 32) begin bad++; $display("FAIL ill_count got %0d want 32", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if ({obs_q[i].re, obs_q[i].im, obs_q[i].sop, obs_q[i].eop, obs_q[i].pts} !==
          {exp_q[i].re, exp_q[i].im, exp_q[i].sop, exp_q[i].eop, exp_q[i].pts}) begin
        bad++;
        $display("FAIL ill_beat[%0d] got %h/%h sop=%b eop=%b pts=%0d want %h/%h sop=%b eop=%b pts=%0d", i,
                 obs_q[i].re, obs_q[i].im, obs_q[i].sop, obs_q[i].eop, obs_q[i].pts,
                 exp_q[i].re, exp_q[i].im, exp_q[i].sop, exp_q[i].eop, exp_q[i].pts);
      end
    end
    total++; if (done_cnt - d0 != 2) begin bad++; $display("FAIL ill_frame_done got %0d want 2", done_cnt - d0); end
  endtask

  task automatic test_reset_midframe();
    int d0;
    clear_q();
    cfg_log2n = 3'd4;
    send(5, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if ({bus.sink_valid, bus.in_ready, bus.sink_sop, bus.sink_eop} !== 4'b0000) begin bad++; $display("FAIL midrst_outputs got valid/ready/sop/eop=%b want 0000", {bus.sink_valid, bus.in_ready, bus.sink_sop, bus.sink_eop}); end
    total++; if ({cfg_err, bus.fftpts_in} !== {1'b0, 5'd16}) begin bad++; $display("FAIL midrst_cfg got err=%b pts=%0d want 0/16", cfg_err, bus.fftpts_in); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_q();
    d0 = done_cnt;
    send(16, 15);
    build_exp();
    drain();
    total++; if (obs_q.size() != 16) begin bad++; $display("FAIL midrst_count got %0d want 16", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if ({obs_q[i].re, obs_q[i].im, obs_q[i].sop, obs_q[i].eop, obs_q[i].pts} !==
          {exp_q[i].re, exp_q[i].im, exp_q[i].sop, exp_q[i].eop, exp_q[i].pts}) begin
        bad++;
        $display("FAIL midrst_beat[%0d] got %h/%h sop=%b eop=%b pts=%0d want %h/%h sop=%b eop=%b pts=%0d", i,
                 obs_q[i].re, obs_q[i].im, obs_q[i].sop, obs_q[i].eop, obs_q[i].pts,
                 exp_q[i].re, exp_q[i].im, exp_q[i].sop, exp_q[i].eop, exp_q[i].pts);
      end
    end
    if (obs_q.size() > 0) begin
      total++; if (obs_q[0].sop !== 1'b1) begin bad++; $display("FAIL midrst_first_sop got %b want 1", obs_q[0].sop); end
    end
    total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL midrst_frame_done got %0d want 1", done_cnt - d0); end
  endtask

`ifdef FFT_PACK_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_q();
    cfg_log2n = 3'd2;
    sr_mode = 2;
    bus.sink_ready = 1'b0;
    send(1, 0);
    repeat (6) @(posedge clk);
    #1;
    bus.sink_ready = 1'b1;
    sr_mode = 0;
    send(11, 0);
    build_exp();
    drain();
    total++; if (frame_count !== 16'd3) begin bad++; $display("FAIL stats_frame_count got %0d want 3", frame_count); end
    total++; if (stall_count !== 16'd6) begin bad++; $display("FAIL stats_stall_count got %0d want 6", stall_count); end
  endtask
`endif

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_real    = '0;
    bus.in_imag    = '0;
    bus.sink_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_cfg_change();
    test_cfg_illegal();
    test_reset_midframe();
`ifdef FFT_PACK_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
